dmem_responder: RTL and testbench

Data-memory responder for the milano core's data interface: the memory-side end of the req/gnt/rvalid protocol driven by the load/store unit. It accepts one request at a time, grants it in the request cycle, and returns a single rvalid pulse a fixed, programmable number of cycles later. Reads return the full addressed word; writes commit the byte lanes selected by data_be. It serves as the on-chip data RAM in the core testbench and FPGA top.

---
 rtl/milano_pkg.sv | 12 +
 rtl/dmem_ram.sv | 29 ++
 rtl/dmem_responder.sv | 102 ++++++++++
 tb/tb_dmem_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/milano_pkg.sv
// Shared types and constants for the milano core's memory-side blocks.
package milano_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_ram.sv
// Word array with per-byte synchronous write and asynchronous read; not reset.
module dmem_ram
    import milano_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [DATA_W-1:0]              wdata_i,
    output logic [DATA_W-1:0]              rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (be_i[n]) begin
                    mem[idx_i][8*n +: 8] <= wdata_i[8*n +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the data req/gnt/rvalid protocol: one request in flight,
// fixed programmable response latency, byte-enabled writes, range checking.
module dmem_responder
    import milano_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_req_i,
    output logic              data_gnt_o,
    input  logic [31:0]       data_addr_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(4 * DEPTH_WORDS);
    localparam dmem_state_e GRANT_NEXT = (LATENCY == 1) ? RESP : WAIT;

    dmem_state_e       state_q, state_d;
    logic [2:0]        cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ok_q;

    logic [32:0]       addr_ext;
    logic [31:0]       offset;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // 33-bit compare so a base near the top of the address space cannot wrap.
    assign addr_ext = {1'b0, data_addr_i};
    assign in_range = (addr_ext >= {1'b0, BASE_ADDR}) && (addr_ext < ({1'b0, BASE_ADDR} + SPAN));
    assign offset   = data_addr_i - BASE_ADDR;
    assign idx      = IDX_W'(offset >> 2);

    assign data_gnt_o = data_req_i & ((state_q == IDLE) | (state_q == RESP));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_gnt_o) state_d = GRANT_NEXT;
            WAIT:    if (cnt_q <= 3'd1) state_d = RESP;
            RESP:    state_d = data_gnt_o ? GRANT_NEXT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (data_gnt_o) begin
                cnt_q   <= 3'(LATENCY - 1);
                idx_q   <= idx;
                we_q    <= data_we_i;
                be_q    <= data_be_i;
                wdata_q <= data_wdata_i;
                ok_q    <= in_range;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    // Reset is folded in so a RESP edge that coincides with reset never commits.
    assign ram_we = (state_q == RESP) & we_q & ok_q & ~rst_i;

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .be_i    (be_q),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign data_rvalid_o = (state_q == RESP);
    assign data_rdata_o  = (data_rvalid_o && !we_q && ok_q) ? ram_rdata : '0;
    assign data_err_o    = data_rvalid_o & ~ok_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder at LATENCY 1, 3 and 4 against a word-array model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;

    int          lat [3];
    logic [31:0] model [3][DEPTH];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(BASE)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .BASE_ADDR(BASE)) u_lat4 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

    function automatic logic in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 4 * DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) & (DEPTH - 1));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int n = 0; n < 4; n++) if (b[n]) r[8*n +: 8] = d[8*n +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
        if (r == 1) return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
        if (r == 2) return $urandom();
        return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
    endfunction

    // Issues one transaction on instance k starting just after a rising edge;
    // returns just after the edge that ends the response cycle.
    task automatic run_txn(input int k, input logic [31:0] a, input logic w,
                           input logic [3:0] b, input logic [31:0] d);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        ok;
        int          idx;
        ok      = in_rng(a);
        idx     = widx(a);
        exp_err = !ok;
        exp_rd  = (ok && !w) ? model[k][idx] : 32'h0;
        addr = a; we = w; be = b; wdata = d; req[k] = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt[k] !== 1'b1 || rvalid[k] !== 1'b0) begin
            errors++;
            $display("FAIL txn_grant inst%0d addr=%h: gnt=%b rvalid=%b, want gnt=1 rvalid=0",
                     k, a, gnt[k], rvalid[k]);
        end
        @(posedge clk); #1;
        req[k] = 1'b0; addr = $urandom(); we = 1'($urandom_range(0, 1));
        be = 4'($urandom()); wdata = $urandom();
        for (int c = 1; c <= lat[k]; c++) begin
            @(negedge clk);
            checks++;
            if (c == lat[k]) begin
                if (rvalid[k] !== 1'b1 || rdata[k] !== exp_rd || err[k] !== exp_err) begin
                    errors++;
                    $display("FAIL txn_resp inst%0d addr=%h we=%b: rvalid=%b rdata=%h err=%b, want 1 %h %b",
                             k, a, w, rvalid[k], rdata[k], err[k], exp_rd, exp_err);
                end
            end else if (rvalid[k] !== 1'b0 || rdata[k] !== 32'h0 || err[k] !== 1'b0) begin
                errors++;
                $display("FAIL txn_wait inst%0d cycle %0d: rvalid=%b rdata=%h err=%b, want 0 0 0",
                         k, c, rvalid[k], rdata[k], err[k]);
            end
            @(posedge clk); #1;
        end
        if (ok && w) model[k][idx] = merge(model[k][idx], d, b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (gnt[k] !== 1'b0 || rvalid[k] !== 1'b0 || rdata[k] !== 32'h0 || err[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d: gnt=%b rvalid=%b rdata=%h err=%b, want all 0",
                         k, gnt[k], rvalid[k], rdata[k], err[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_init();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < DEPTH; i++) begin
                model[k][i] = 32'h0;
                run_txn(k, BASE + 32'(4 * i), 1'b1, 4'hF, $urandom());
            end
    endtask

    task automatic test_back_to_back();
        addr = BASE + 32'h8; we = 1'b1; be = 4'hF; wdata = 32'hDEAD_BEEF; req[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt[0] !== 1'b1 || rvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cycle0: gnt=%b rvalid=%b, want 1 0", gnt[0], rvalid[0]);
        end
        @(posedge clk); #1;
        we = 1'b0; wdata = 32'h0;
        @(negedge clk);
        checks++;
        if (gnt[0] !== 1'b1 || rvalid[0] !== 1'b1 || rdata[0] !== 32'h0 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cycle1: gnt=%b rvalid=%b rdata=%h err=%b, want 1 1 0 0",
                     gnt[0], rvalid[0], rdata[0], err[0]);
        end
        @(posedge clk); #1;
        req[0] = 1'b0;
        model[0][2] = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (gnt[0] !== 1'b0 || rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL b2b_cycle2: gnt=%b rvalid=%b rdata=%h, want 0 1 deadbeef",
                     gnt[0], rvalid[0], rdata[0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cycle3: rvalid=%b, want 0", rvalid[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_be_merge();
        for (int k = 0; k < 3; k++) begin
            run_txn(k, BASE + 32'h10, 1'b1, 4'hF, 32'h1122_3344);
            run_txn(k, BASE + 32'h10, 1'b1, 4'b0101, 32'hAABB_CCDD);
            run_txn(k, BASE + 32'h10, 1'b0, 4'hF, 32'h0);
            run_txn(k, BASE + 32'h10, 1'b1, 4'b0000, $urandom());
            run_txn(k, BASE + 32'h10, 1'b0, 4'b0000, 32'h0);
        end
    endtask

    task automatic test_latency4();
        logic [31:0] exp1, exp2;
        exp1 = model[2][5];
        exp2 = model[2][6];
        addr = BASE + 32'h14; we = 1'b0; be = 4'hF; req[2] = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (c == 0 && (gnt[2] !== 1'b1 || rvalid[2] !== 1'b0)) begin
                errors++;
                $display("FAIL lat4_grant: gnt=%b rvalid=%b, want 1 0", gnt[2], rvalid[2]);
            end else if ((c inside {[1:3], [5:7]}) && (gnt[2] !== 1'b0 || rvalid[2] !== 1'b0)) begin
                errors++;
                $display("FAIL lat4_wait cycle %0d: gnt=%b rvalid=%b, want 0 0", c, gnt[2], rvalid[2]);
            end else if (c == 4 && (gnt[2] !== 1'b1 || rvalid[2] !== 1'b1 || rdata[2] !== exp1)) begin
                errors++;
                $display("FAIL lat4_resp1: gnt=%b rvalid=%b rdata=%h, want 1 1 %h",
                         gnt[2], rvalid[2], rdata[2], exp1);
            end else if (c == 8 && (gnt[2] !== 1'b0 || rvalid[2] !== 1'b1 || rdata[2] !== exp2)) begin
                errors++;
                $display("FAIL lat4_resp2: gnt=%b rvalid=%b rdata=%h, want 0 1 %h",
                         gnt[2], rvalid[2], rdata[2], exp2);
            end
            @(posedge clk); #1;
            if (c == 0) addr = BASE + 32'h18;
            if (c == 4) begin req[2] = 1'b0; addr = $urandom(); end
        end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 3; k++) begin
            run_txn(k, 32'h0000_FFFC, 1'b1, 4'hF, $urandom());
            run_txn(k, BASE + 32'(4 * DEPTH), 1'b1, 4'hF, $urandom());
            run_txn(k, 32'h0000_FFFC, 1'b0, 4'hF, 32'h0);
            run_txn(k, BASE, 1'b0, 4'hF, 32'h0);
            run_txn(k, BASE + 32'(4 * (DEPTH - 1)), 1'b0, 4'hF, 32'h0);
        end
    endtask

    task automatic test_misaligned();
        for (int k = 0; k < 3; k++) begin
            run_txn(k, BASE + 32'h13, 1'b0, 4'b1000, 32'h0);
            run_txn(k, BASE + 32'h13, 1'b1, 4'b1000, $urandom());
            run_txn(k, BASE + 32'h11, 1'b0, 4'b0010, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        addr = BASE + 32'h8; we = 1'b1; be = 4'hF; wdata = 32'hFFFF_FFFF; req[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt[1] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant: gnt=%b, want 1", gnt[1]);
        end
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (gnt[1] !== 1'b0 || rvalid[1] !== 1'b0 || rdata[1] !== 32'h0 || err[1] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: gnt=%b rvalid=%b rdata=%h err=%b, want all 0",
                     gnt[1], rvalid[1], rdata[1], err[1]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (rvalid[1] !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_rvalid cycle %0d: rvalid=%b, want 0", c, rvalid[1]);
            end
            @(posedge clk); #1;
        end
        run_txn(1, BASE + 32'h8, 1'b0, 4'hF, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            int k;
            k = $urandom_range(0, 2);
            run_txn(k, rand_addr(), 1'($urandom_range(0, 1)), 4'($urandom()), $urandom());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        lat[0] = 1; lat[1] = 3; lat[2] = 4;
        addr = '0; we = 1'b0; be = '0; wdata = '0;
        test_reset();
        test_init();
        test_back_to_back();
        test_be_merge();
        test_latency4();
        test_out_of_range();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
